keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad on the Pmod header, debounces it, and delivers one key code per press to the stopwatch control logic. The rows are time-multiplexed as outputs and the columns are sampled as inputs. Each code is held under a valid/ready handshake until the consumer accepts it, with a sticky overflow flag.

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/keypad_row_scan.sv | 58 +++++
 rtl/keypad_scanner.sv | 176 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   kp_state_e   - debounce FSM states
//   KEY_CODE_W   - width of the emitted key code (row*COLS + col)
//   REPEAT_FIRST - held frames before the first auto-repeat (KEYPAD_REPEAT_EN builds)
//   REPEAT_NEXT  - held frames between subsequent auto-repeats
`timescale 1ns/1ps
package keypad_pkg;

  localparam int KEY_CODE_W   = 4;
  localparam int REPEAT_FIRST = 16;
  localparam int REPEAT_NEXT  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

endpackage

// File: rtl/keypad_row_scan.sv
// keypad_row_scan: row time-multiplexing and frame assembly for a matrix keypad.
// Ports:
//   clk, nrst   - clock, asynchronous active-low reset
//   ncol        - active-low column sense (asynchronous, synchronised here)
//   nrow        - active-low row drive, exactly one bit low
//   frame       - one bit per key (row*COLS + col), 1 = closed
//   frame_done  - one-cycle pulse once the last row of a frame has been written
`timescale 1ns/1ps
module keypad_row_scan #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 800
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [COLS-1:0]        ncol,
  output logic [ROWS-1:0]        nrow,
  output logic [ROWS*COLS-1:0]   frame,
  output logic                   frame_done
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div;
  logic [1:0]       row;
  logic [COLS-1:0]  col_meta;
  logic [COLS-1:0]  col_sync;
  logic             sample;
  logic             advance;

  assign sample = (div == DIV_W'(SCAN_DIV - 1));
  assign nrow   = ~(ROWS'(1) << row);

  // The row moves one cycle after its columns are sampled, so each row's
  // sample point sees columns that have settled for SCAN_DIV-1 cycles.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div        <= '0;
      row        <= '0;
      col_meta   <= '1;
      col_sync   <= '1;
      frame      <= '0;
      frame_done <= 1'b0;
      advance    <= 1'b0;
    end else begin
      col_meta   <= ncol;
      col_sync   <= col_meta;
      advance    <= sample;
      frame_done <= sample && (row == 2'(ROWS - 1));
      div        <= sample ? '0 : div + 1'b1;
      if (sample)
        frame[row*COLS +: COLS] <= ~col_sync;
      if (advance)
        row <= (row == 2'(ROWS - 1)) ? '0 : row + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and valid/ready output.
// Ports:
//   clk, nrst  - clock, asynchronous active-low reset
//   nrow       - active-low row drive
//   ncol       - active-low column sense
//   key_valid  - key_code holds an unconsumed press
//   key_code   - row*COLS + col of the pressed key, stable while key_valid
//   key_ready  - consumer accepts key_code when key_valid && key_ready
//   key_down   - debounced single-key-held level
//   overflow   - sticky, a press was dropped while key_valid was pending
// Build option: define KEYPAD_REPEAT_EN to auto-repeat a held key
// (first after REPEAT_FIRST held frames, then every REPEAT_NEXT frames).
`timescale 1ns/1ps
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 800,
  parameter int DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic [ROWS-1:0]       nrow,
  input  logic [COLS-1:0]       ncol,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  input  logic                  key_ready,
  output logic                  key_down,
  output logic                  overflow
);

  localparam int NKEYS = ROWS * COLS;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [NKEYS-1:0]      frame;
  logic                  frame_done;
  logic                  frame_one;
  logic [KEY_CODE_W-1:0] hit_code;
  logic                  single_cand;

  kp_state_e             state, state_next;
  logic [KEY_CODE_W-1:0] cand, cand_next;
  logic [CNT_W-1:0]      cnt, cnt_next, cnt_inc;
  logic                  emit;

  keypad_row_scan #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_row_scan (
    .clk        (clk),
    .nrst       (nrst),
    .ncol       (ncol),
    .nrow       (nrow),
    .frame      (frame),
    .frame_done (frame_done)
  );

  // Exactly one bit set means a clean single press; any ghosted multi-key
  // frame fails the power-of-two test and is treated like a release.
  always_comb begin
    frame_one = (|frame) && ((frame & (frame - 1'b1)) == '0);
    hit_code  = '0;
    for (int unsigned i = 0; i < NKEYS; i++)
      if (frame[i])
        hit_code = KEY_CODE_W'(i);
  end

  assign single_cand = frame_one && (hit_code == cand);
  assign cnt_inc     = cnt + 1'b1;
  assign key_down    = (state == HELD) || (state == REL_DB);

`ifdef KEYPAD_REPEAT_EN
  logic [4:0] rpt_cnt, rpt_cnt_next;
  logic       rpt_on, rpt_on_next;
`endif

  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    emit       = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: if (frame_one) begin
          cand_next = hit_code;
          cnt_next  = CNT_W'(1);
          if (DEBOUNCE == 1) begin
            state_next = HELD;
            emit       = 1'b1;
          end else begin
            state_next = PRESS_DB;
          end
        end
        PRESS_DB: if (single_cand) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(DEBOUNCE)) begin
            state_next = HELD;
            emit       = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
        HELD: if (!single_cand) begin
          cnt_next   = CNT_W'(1);
          state_next = (DEBOUNCE == 1) ? IDLE : REL_DB;
        end
        REL_DB: if (single_cand) begin
          state_next = HELD;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(DEBOUNCE))
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_next = rpt_cnt;
    rpt_on_next  = rpt_on;
    if (state_next != HELD) begin
      rpt_cnt_next = '0;
      rpt_on_next  = 1'b0;
    end else if (frame_done && (state == HELD)) begin
      if (rpt_cnt == 5'(rpt_on ? REPEAT_NEXT - 1 : REPEAT_FIRST - 1)) begin
        emit         = 1'b1;
        rpt_cnt_next = '0;
        rpt_on_next  = 1'b1;
      end else begin
        rpt_cnt_next = rpt_cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt <= '0;
      rpt_on  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cand  <= cand_next;
      cnt   <= cnt_next;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt <= rpt_cnt_next;
      rpt_on  <= rpt_on_next;
`endif
    end
  end

  // A new code may replace one being consumed on the same edge; otherwise
  // a pending code is kept and the newcomer is dropped as an overflow.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else if (emit) begin
      if (key_valid && !key_ready) begin
        overflow <= 1'b1;
      end else begin
        key_code  <= cand_next;
        key_valid <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = ROWS * SCAN_DIV;
  localparam int LAT      = (DEBOUNCE + 1) * FRAME + 3;

  logic            clk = 1'b0;
  logic            nrst;
  logic [ROWS-1:0] nrow;
  logic [COLS-1:0] ncol;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            key_ready;
  logic            key_down;
  logic            overflow;

  logic [15:0]     keys;
  int unsigned     n_vec = 0;
  int unsigned     n_err = 0;
  int unsigned     cyc = 0;
  int unsigned     got_code[$];
  int unsigned     got_time[$];
  logic            kd_seen;
  logic            found;
  int unsigned     t_mark;

  keypad_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .nrow      (nrow),
    .ncol      (ncol),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Switch matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    ncol = '1;
    for (int r = 0; r < ROWS; r++)
      if (!nrow[r])
        for (int c = 0; c < COLS; c++)
          if (keys[r*COLS + c])
            ncol[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid && key_ready) begin
      got_code.push_back(int'(key_code));
      got_time.push_back(cyc);
    end
    if (key_down)
      kd_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_code.delete();
    got_time.delete();
    kd_seen = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nrst      = 1'b0;
    keys      = '0;
    key_ready = 1'b1;
    kd_seen   = 1'b0;
    found     = 1'b0;
    t_mark    = 0;

    // Reset state and row walk
    repeat (5) @(posedge clk);
    #1;
    check("rst_nrow", 32'(nrow), 32'b1110);
    check("rst_valid", 32'(key_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_down", 32'(key_down), 0);
    check("rst_code", 32'(key_code), 0);
    nrst = 1'b1;
    cycles(5);  check("walk_1101", 32'(nrow), 32'b1101);
    cycles(4);  check("walk_1011", 32'(nrow), 32'b1011);
    cycles(4);  check("walk_0111", 32'(nrow), 32'b0111);
    cycles(4);  check("walk_1110", 32'(nrow), 32'b1110);

    // Single press, row2/col1 -> code 9
    clear_log();
    keys[9] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < LAT && !found; i++) begin
      @(posedge clk); #1;
      if (key_valid) found = 1'b1;
    end
    check("press9_seen", 32'(found), 1);
    check("press9_code", 32'(key_code), 9);
    cycles(8 * FRAME);
    check("press9_down", 32'(key_down), 1);
    check("press9_count", got_code.size(), 1);
    check("press9_log", got_code.size() > 0 ? got_code[0] : 99, 9);
    keys[9] = 1'b0;
    t_mark = cyc;
    cycles(12);
    check("rel9_still_down", 32'(key_down), 1);
    found = 1'b0;
    for (int i = 0; i < LAT && !found; i++) begin
      @(posedge clk); #1;
      if (!key_down) found = 1'b1;
    end
    check("rel9_up", 32'(found), 1);
    check("rel9_not_early", 32'(cyc - t_mark >= 2 * FRAME), 1);
    cycles(3 * FRAME);

    // Bouncing contact on key 0, then stable
    clear_log();
    keys[0] = 1'b1;
    repeat (5) begin
      cycles(10);
      keys[0] = ~keys[0];
    end
    keys[0] = 1'b1;
    cycles(6 * FRAME);
    check("bounce_count", got_code.size(), 1);
    check("bounce_code", got_code.size() > 0 ? got_code[0] : 99, 0);
    check("bounce_down", 32'(key_down), 1);
    keys[0] = 1'b0;
    cycles(6 * FRAME);
    check("bounce_up", 32'(key_down), 0);

    // Ghost pair 5 + 6
    clear_log();
    keys[5] = 1'b1;
    keys[6] = 1'b1;
    cycles(8 * FRAME);
    check("ghost_count", got_code.size(), 0);
    check("ghost_down", 32'(kd_seen), 0);
    keys = '0;
    cycles(2 * FRAME);

    // Backpressure and overflow
    clear_log();
    key_ready = 1'b0;
    keys[3] = 1'b1;
    cycles(5 * FRAME);
    check("bp_valid3", 32'(key_valid), 1);
    check("bp_code3", 32'(key_code), 3);
    check("bp_ovf0", 32'(overflow), 0);
    keys[3] = 1'b0;
    cycles(5 * FRAME);
    keys[12] = 1'b1;
    cycles(5 * FRAME);
    check("bp_valid12", 32'(key_valid), 1);
    check("bp_code_kept", 32'(key_code), 3);
    check("bp_ovf1", 32'(overflow), 1);
    check("bp_down12", 32'(key_down), 1);
    keys[12] = 1'b0;
    cycles(5 * FRAME);
    key_ready = 1'b1;
    cycles(1);
    check("bp_consumed", 32'(key_valid), 0);
    check("bp_ovf_sticky", 32'(overflow), 1);
    check("bp_log_count", got_code.size(), 1);
    check("bp_log_code", got_code.size() > 0 ? got_code[0] : 99, 3);

    // Reset during debounce abandons the candidate
    clear_log();
    keys[10] = 1'b1;
    cycles(2 * FRAME);
    nrst = 1'b0;
    keys = '0;
    cycles(3);
    check("rst2_nrow", 32'(nrow), 32'b1110);
    check("rst2_ovf", 32'(overflow), 0);
    nrst = 1'b1;
    cycles(5 * FRAME);
    check("rst2_count", got_code.size(), 0);
    check("rst2_valid", 32'(key_valid), 0);
    check("rst2_down", 32'(key_down), 0);

    // Long hold on key 15
    clear_log();
    keys[15] = 1'b1;
    cycles(29 * FRAME);
    keys[15] = 1'b0;
    cycles(5 * FRAME);
`ifdef KEYPAD_REPEAT_EN
    check("hold_count", got_code.size(), 4);
    for (int i = 0; i < 4; i++)
      check("hold_code", got_code.size() > i ? got_code[i] : 99, 15);
    if (got_time.size() == 4) begin
      check("rpt_gap_first", got_time[1] - got_time[0], 16 * FRAME);
      check("rpt_gap_2", got_time[2] - got_time[1], 4 * FRAME);
      check("rpt_gap_3", got_time[3] - got_time[2], 4 * FRAME);
    end
`else
    check("hold_count", got_code.size(), 1);
    check("hold_code", got_code.size() > 0 ? got_code[0] : 99, 15);
`endif
    check("hold_up", 32'(key_down), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
